adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one 16-bit signed combinational adder (`adder`) among NUM_REQ requesters.
- Round-robin grant with a per-requester valid/ready handshake.
- Two-stage pipeline: operand register, then result register. The result register sits behind a single response port with backpressure.
- Sits between the ALU-side requesters (address calc, PC increment, execute) and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width, two's-complement signed.
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.
- SATURATE, 0, 1 = clamp result on overflow; 0 = wrap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_sum  out  WIDTH  signed sum (wrapped or saturated).
- resp_ovf  out  1  signed overflow occurred on this add.
- busy  out  1  either pipeline stage occupied.

Behaviour:
- Reset (async assert, sync-safe deassert on clk):
  - s1_valid = 0, s2_valid = 0 (so resp_valid = 0).
  - resp_id = 0, resp_sum = 0, resp_ovf = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation drops all in-flight requests with no response.
- Stall / advance:
  - s2_free = !s2_valid | resp_ready.
  - s1_free = !s1_valid | s2_free.
- Arbitration (combinational):
  - When s1_free, grant the first asserted req_valid scanning from rr_ptr+1 mod NUM_REQ upward with wrap.
  - req_ready is one-hot or zero. It never asserts for a requester whose req_valid is low.
  - req_ready is all-zero when !s1_free.
- On handshake:
  - Stage 1 captures A, B, id; s1_valid <= 1.
  - rr_ptr <= granted id. rr_ptr is unchanged if there is no handshake.
- Stage 2:
  - When s2_free and s1_valid: load resp_sum/resp_ovf from the adder output on the s1 operands, plus resp_id; s2_valid <= 1.
  - Else if resp_ready: s2_valid <= 0.
  - s1_valid <= handshake | (s1_valid & !s2_free).
- Latency and throughput:
  - Handshake in cycle N gives resp_valid in cycle N+2 with no backpressure.
  - Sustained throughput is 1 result per cycle.
- Overflow:
  - ovf = (A[MSB] == B[MSB]) & (sum[MSB] != A[MSB]).
  - SATURATE=0: resp_sum is the wrapped sum.
  - SATURATE=1 and ovf: resp_sum = 0x7FFF if A positive, 0x8000 if A negative.
  - resp_ovf reports ovf in both modes.
- Output hold:
  - resp_* stay stable while resp_valid & !resp_ready.
  - Ordering is strictly in grant order; there is no reordering.
- Simultaneous events:
  - A handshake and a stage-2 drain in the same cycle are both honoured; a full pipeline keeps flowing.
  - A requester dropping req_valid without a grant is legal. No grant is retained.
- busy = s1_valid | s2_valid.

Decomposition:
- Package `adder_pkg`:
  - WIDTH default.
  - MAX_POS = 16'h7FFF, MAX_NEG = 16'h8000.
  - typedef for the response record {id, sum, ovf}.
- One sub-module, `rr_arbiter`:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and encoded id.
- The existing `adder` is instantiated unchanged.

Test Plan:
- Req0 a=50 b=150, resp_ready=1 -> resp_valid 2 cycles after handshake, resp_id=0, sum=200, ovf=0.
- Req2 a=1250 b=-1300 -> sum=-50, ovf=0, resp_id=2.
- Req1 a=30000 b=10000, SATURATE=0 -> sum=-25536, ovf=1; with SATURATE=1 -> sum=32767, ovf=1. Also a=-30000 b=-10000, SATURATE=1 -> sum=-32768, ovf=1.
- All 4 req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, one result per cycle, resp_id matches order.
- resp_ready=0 for 5 cycles with continuous requests:
  - exactly 2 handshakes (s1 + s2 fill), then req_ready=0;
  - resp_* stable during the stall;
  - on release, results drain in grant order with no loss or duplication.
- Assert rst_n=0 while both stages are valid -> resp_valid=0 and busy=0 immediately. After release, req3 only -> granted first cycle, resp_id=3.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and types for the adder arbiter slice.
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ID_W  = 2;

  localparam logic [DEF_WIDTH-1:0] MAX_POS = 16'h7FFF;
  localparam logic [DEF_WIDTH-1:0] MAX_NEG = 16'h8000;

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_WIDTH-1:0] sum;
    logic                 ovf;
  } resp_t;
endpackage

// File: rtl/adder.sv
// Shared combinational two's-complement adder.
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    if (en) begin
      // Scan farthest-first so the nearest requester after ptr overwrites last and wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % NUM_REQ]) begin
          gnt = '0;
          gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
          gnt_id = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared signed adder: operand stage, then result stage behind a
// backpressured response port.
module adder_arbiter import adder_pkg::*; #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ID_W     = DEF_ID_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_ovf,
  output logic                     busy
);
  logic               s1_valid, s2_valid, s1_free, s2_free, hs;
  logic [ID_W-1:0]    rr_ptr, gnt_id, s1_id;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   sel_a, sel_b, s1_a, s1_b, raw_sum, nxt_sum;
  logic               nxt_ovf;

  assign s2_free = !s2_valid || resp_ready;
  assign s1_free = !s1_valid || s2_free;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (s1_free),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (.a(s1_a), .b(s1_b), .sum(raw_sum));

  always_comb begin
    nxt_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (raw_sum[WIDTH-1] != s1_a[WIDTH-1]);
    nxt_sum = raw_sum;
    // Clamp toward the sign of the operands (both share A's sign on overflow).
    if (SATURATE && nxt_ovf)
      nxt_sum = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      s1_valid <= hs || (s1_valid && !s2_free);
      if (hs) begin
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        s1_id  <= gnt_id;
        rr_ptr <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      resp_id  <= '0;
      resp_sum <= '0;
      resp_ovf <= 1'b0;
    end else if (s2_free && s1_valid) begin
      s2_valid <= 1'b1;
      resp_id  <= s1_id;
      resp_sum <= nxt_sum;
      resp_ovf <= nxt_ovf;
    end else if (resp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign resp_valid = s2_valid;
  assign busy       = s1_valid || s2_valid;
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench: grants push hand-computed expectations, a monitor pops on
// each accepted response. A second instance runs with saturation enabled.
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_ready;
  logic [N-1:0]   req_ready, sat_req_ready;
  logic           resp_valid, sat_valid, resp_ovf, sat_ovf, busy, sat_busy;
  logic [1:0]     resp_id, sat_id;
  logic [W-1:0]   resp_sum, sat_sum;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_ovf(resp_ovf), .busy(busy));

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(sat_req_ready), .resp_valid(sat_valid), .resp_ready(resp_ready),
    .resp_id(sat_id), .resp_sum(sat_sum), .resp_ovf(sat_ovf), .busy(sat_busy));

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int sat;
    int ovf;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_gnt_q[$];
  int   exp_w[N], exp_s[N], exp_o[N];
  int   checks = 0, errors = 0, hs_count = 0, cyc = 0;
  bit   lat_chk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int w, input int s, input int o);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    exp_w[i] = w;
    exp_s[i] = s;
    exp_o[i] = o;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    tick(1);
    chk("drain_empty", sb.size(), 0);
    chk("grants_consumed", exp_gnt_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: grant legality, grant order, expectation push.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
      chk("ready_subset", int'(req_ready & ~req_valid), 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          hs_count++;
          if (exp_gnt_q.size() == 0) chk("grant_unexpected", i, -1);
          else chk("grant_order", i, exp_gnt_q.pop_front());
          e.id = i; e.sum = exp_w[i]; e.sat = exp_s[i]; e.ovf = exp_o[i]; e.cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  // Response monitor: compares the front entry every valid cycle, pops on accept.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", int'(resp_id), -1);
      end else begin
        chk("resp_id", int'(resp_id), sb[0].id);
        chk("resp_sum", int'($signed(resp_sum)), sb[0].sum);
        chk("resp_ovf", int'(resp_ovf), sb[0].ovf);
        chk("sat_valid", int'(sat_valid), 1);
        chk("sat_sum", int'($signed(sat_sum)), sb[0].sat);
        chk("sat_ovf", int'(sat_ovf), sb[0].ovf);
        if (resp_ready) begin
          if (lat_chk) chk("latency", cyc - sb[0].cyc, 2);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 0, 0, 0, 0, 0);
    tick(2);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_sum", int'(resp_sum), 0);
    chk("rst_resp_ovf", int'(resp_ovf), 0);
    rst_n = 1'b1;
    tick(1);

    // Single requests with the pipeline otherwise idle.
    lat_chk = 1'b1;
    set_op(0, 50, 150, 200, 200, 0);
    exp_gnt_q.push_back(0);
    req_valid = 4'b0001;
    #1 chk("first_grant_req0", int'(req_ready), 1);
    tick(1); req_valid = '0;
    drain();

    set_op(2, 1250, -1300, -50, -50, 0);
    exp_gnt_q.push_back(2);
    req_valid = 4'b0100; tick(1); req_valid = '0;
    drain();

    set_op(1, 30000, 10000, -25536, 32767, 1);
    exp_gnt_q.push_back(1);
    req_valid = 4'b0010; tick(1); req_valid = '0;
    drain();

    set_op(1, -30000, -10000, 25536, -32768, 1);
    exp_gnt_q.push_back(1);
    req_valid = 4'b0010; tick(1); req_valid = '0;
    drain();

    // Fresh reset, then all four requesters held for eight cycles.
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    set_op(0, 1, 2, 3, 3, 0);
    set_op(1, -5, 3, -2, -2, 0);
    set_op(2, 32767, 1, -32768, 32767, 1);
    set_op(3, -32768, -1, 32767, -32768, 1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_gnt_q.push_back(i);
    req_valid = '1; tick(8); req_valid = '0;
    drain();

    // Backpressure: only two requests fit before the arbiter stops granting.
    lat_chk = 1'b0;
    hs_count = 0;
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(1);
    resp_ready = 1'b0;
    req_valid = '1;
    tick(5);
    chk("stall_handshakes", hs_count, 2);
    chk("stall_ready_zero", int'(req_ready), 0);
    chk("stall_busy", int'(busy), 1);
    req_valid = '0;
    resp_ready = 1'b1;
    drain();

    // Reset with both stages full drops everything.
    exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3);
    resp_ready = 1'b0;
    req_valid = '1;
    tick(3);
    chk("prefill_resp_valid", int'(resp_valid), 1);
    chk("prefill_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    req_valid = '0;
    sb.delete();
    exp_gnt_q.delete();
    #1;
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    lat_chk = 1'b1;
    set_op(3, 100, -1, 99, 99, 0);
    exp_gnt_q.push_back(3);
    req_valid = 4'b1000;
    #1 chk("post_rst_grant3", int'(req_ready), 8);
    tick(1); req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
